// File: rtl/ps2_kbd_responder.sv
// PS/2 keyboard receiver for the 0xe dmem region.
// Decodes 11-bit scan-code frames into a byte FIFO. CPU reads return data
// combinationally in the same cycle. Error and overflow status is in a
// separate register.
module ps2_kbd_responder #(
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        rd_en,
    input  logic        reg_sel,
    input  logic        pipe_stall,
    output logic [31:0] rd_data,
    output logic        kbd_avail
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned FW    = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          state, state_nxt;
    logic [1:0]      clk_sync, data_sync;
    logic [FW-1:0]   filt_cnt;
    logic            filt_level, filt_prev;
    logic            fall, din;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            parity_bit;
    logic [TW-1:0]   to_cnt;
    logic            timeout_c, push_c, frame_err_c;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0]      count;
    logic               overflow;
    logic [7:0]         err_cnt;
    logic               empty, full, pop_c, wr_c, drop_c, status_rd_c, err_inc_c;

    assign fall      = filt_prev & ~filt_level;
    assign din       = data_sync[1];
    assign timeout_c = (state != S_IDLE) && (to_cnt == TW'(TIMEOUT_CYC));

    // Two-flop synchronizers on both raw pins
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Glitch filter: level follows the synced clock only after FILTER_LEN stable samples
    always_ff @(posedge clk) begin
        if (!rst) begin
            filt_cnt   <= '0;
            filt_level <= 1'b1;
            filt_prev  <= 1'b1;
        end else begin
            filt_prev <= filt_level;
            if (clk_sync[1] == filt_level) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_level <= clk_sync[1];
                filt_cnt   <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Frame FSM next state: moves on falling edges, timeout forces IDLE
    always_comb begin
        state_nxt = state;
        if (timeout_c) begin
            state_nxt = S_IDLE;
        end else if (fall) begin
            case (state)
                S_IDLE:   if (!din) state_nxt = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
                S_PARITY: state_nxt = S_STOP;
                S_STOP:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Frame FSM outputs: frame verdict on the stop-bit edge
    always_comb begin
        push_c      = 1'b0;
        frame_err_c = 1'b0;
        if (!timeout_c && fall && state == S_STOP) begin
            if (din && (^{shreg, parity_bit})) push_c      = 1'b1;
            else                               frame_err_c = 1'b1;
        end
    end

    // Bit shifter and inter-edge timeout counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            to_cnt     <= '0;
        end else begin
            if (state == S_IDLE || timeout_c || fall) to_cnt <= '0;
            else                                      to_cnt <= to_cnt + TW'(1);
            if (fall && !timeout_c) begin
                case (state)
                    S_IDLE:   bit_cnt <= '0;
                    S_DATA: begin
                        shreg   <= {din, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_PARITY: parity_bit <= din;
                    default:  ;
                endcase
            end
        end
    end

    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign pop_c       = rd_en & ~reg_sel & ~pipe_stall & ~empty;
    assign wr_c        = push_c & (~full | pop_c);
    assign drop_c      = push_c & full & ~pop_c;
    assign status_rd_c = rd_en & reg_sel & ~pipe_stall;
    assign err_inc_c   = frame_err_c | timeout_c;
    assign kbd_avail   = ~empty;

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr_c) mem[wr_ptr] <= shreg;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_c)  wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop_c) rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({wr_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Sticky status; a set in the clearing cycle survives the clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
            err_cnt  <= '0;
        end else begin
            overflow <= drop_c | (overflow & ~status_rd_c);
            if (err_inc_c) begin
                if (status_rd_c)           err_cnt <= 8'd1;
                else if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else if (status_rd_c) begin
                err_cnt <= '0;
            end
        end
    end

    // Same-cycle read mux
    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            if (reg_sel)     rd_data = {16'b0, err_cnt, 8'({overflow, count})};
            else if (!empty) rd_data = {24'b0, mem[rd_ptr]};
        end
    end

endmodule

// File: tb/tb_ps2_kbd_responder.sv
// Self-checking bench for ps2_kbd_responder against a queue-based model.
`timescale 1ns/1ps
module tb_ps2_kbd_responder;

    localparam int unsigned TO   = 1000;
    localparam int unsigned HALF = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        rd_en = 1'b0;
    logic        reg_sel = 1'b0;
    logic        pipe_stall = 1'b0;
    logic [31:0] rd_data;
    logic        kbd_avail;

    int checks = 0;
    int errors = 0;

    // Reference model: received bytes, sticky overflow, saturating error count
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    int         m_err = 0;

    ps2_kbd_responder #(.FIFO_AW(4), .FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en), .reg_sel(reg_sel), .pipe_stall(pipe_stall),
        .rd_data(rd_data), .kbd_avail(kbd_avail)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_err = 0;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic good);
        if (good) begin
            if (q.size() < 16) q.push_back(b);
            else m_ovf = 1'b1;
        end else if (m_err < 255) begin
            m_err++;
        end
    endtask

    task automatic model_data(input logic stall, output logic [31:0] exp);
        exp = (q.size() != 0) ? {24'b0, q[0]} : 32'h0;
        if (!stall && q.size() != 0) void'(q.pop_front());
    endtask

    task automatic model_status(input logic stall, output logic [31:0] exp);
        exp = {16'b0, 8'(m_err), 2'b0, m_ovf, 5'(q.size())};
        if (!stall) begin
            m_err = 0;
            m_ovf = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
    endtask

    task automatic do_read(input logic sel, input logic stall, output logic [31:0] val);
        @(negedge clk);
        rd_en = 1'b1; reg_sel = sel; pipe_stall = stall;
        #1 val = rd_data;
        @(posedge clk);
        #1 rd_en = 1'b0; pipe_stall = 1'b0; reg_sel = 1'b0;
    endtask

    // One PS/2 bit: data set while clock high, device then pulls clock low
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        #2 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #2 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic p;
        p = (~^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        model_frame(b, !bad_par);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        checks++;
        if (kbd_avail !== 1'b0) begin errors++; $display("FAIL reset_avail got %b exp 0", kbd_avail); end
        @(negedge clk); #1;
        checks++;
        if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_idle_rd got %h exp 0", rd_data); end
        do_read(1'b1, 1'b0, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", v); end
        do_read(1'b0, 1'b0, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", v); end
    endtask

    task automatic test_single_frame();
        logic [31:0] v, e;
        send_frame(8'h1C, 1'b0);
        checks++;
        if (kbd_avail !== 1'b1) begin errors++; $display("FAIL single_avail got %b exp 1", kbd_avail); end
        do_read(1'b0, 1'b0, v);
        model_data(1'b0, e);
        checks++;
        if (v !== 32'h0000001C || v !== e) begin errors++; $display("FAIL single_data got %h exp 0000001c", v); end
        checks++;
        if (kbd_avail !== 1'b0) begin errors++; $display("FAIL single_avail_after got %b exp 0", kbd_avail); end
    endtask

    task automatic test_parity_error();
        logic [31:0] v;
        send_frame(8'h1C, 1'b1);
        checks++;
        if (kbd_avail !== 1'b0) begin errors++; $display("FAIL parity_avail got %b exp 0", kbd_avail); end
        do_read(1'b1, 1'b0, v);
        checks++;
        if (v !== 32'h00000100) begin errors++; $display("FAIL parity_status got %h exp 00000100", v); end
        m_err = 0;
        do_read(1'b1, 1'b0, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL parity_cleared got %h exp 0", v); end
    endtask

    task automatic test_overflow();
        logic [31:0] v, e;
        for (int i = 0; i < 17; i++) send_frame(8'($urandom), 1'b0);
        do_read(1'b1, 1'b0, v);
        model_status(1'b0, e);
        checks++;
        if (v !== 32'h00000030 || v !== e) begin errors++; $display("FAIL ovf_status got %h exp 00000030", v); end
        for (int i = 0; i < 16; i++) begin
            do_read(1'b0, 1'b0, v);
            model_data(1'b0, e);
            checks++;
            if (v !== e) begin errors++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, v, e); end
        end
        do_read(1'b0, 1'b0, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL ovf_empty got %h exp 0", v); end
    endtask

    task automatic test_stall();
        logic [31:0] v, e;
        for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) begin
            do_read(1'b0, 1'b1, v);
            model_data(1'b1, e);
            checks++;
            if (v !== e) begin errors++; $display("FAIL stall_hold[%0d] got %h exp %h", i, v, e); end
        end
        do_read(1'b0, 1'b0, v);
        model_data(1'b0, e);
        checks++;
        if (v !== e) begin errors++; $display("FAIL stall_release got %h exp %h", v, e); end
        do_read(1'b1, 1'b0, v);
        model_status(1'b0, e);
        checks++;
        if (v !== 32'h00000002 || v !== e) begin errors++; $display("FAIL stall_count got %h exp 00000002", v); end
        while (q.size() != 0) begin
            do_read(1'b0, 1'b0, v);
            model_data(1'b0, e);
            checks++;
            if (v !== e) begin errors++; $display("FAIL stall_drain got %h exp %h", v, e); end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] v, e;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom));
        ps2_data = 1'b1;
        repeat (TO + 2) @(posedge clk);
        model_frame(8'h00, 1'b0);
        do_read(1'b1, 1'b0, v);
        model_status(1'b0, e);
        checks++;
        if (v !== 32'h00000100 || v !== e) begin errors++; $display("FAIL timeout_status got %h exp 00000100", v); end
        send_frame(8'h5A, 1'b0);
        do_read(1'b0, 1'b0, v);
        model_data(1'b0, e);
        checks++;
        if (v !== 32'h0000005A || v !== e) begin errors++; $display("FAIL timeout_next got %h exp 0000005a", v); end
    endtask

    task automatic test_glitch_reset();
        logic [31:0] v, e;
        logic [10:0] fr;
        fr = {1'b1, ~^8'h3C, 8'h3C, 1'b0};
        // Frame with short pulses in both clock phases of every bit
        for (int i = 0; i < 11; i++) begin
            ps2_data = fr[i];
            repeat (10) @(posedge clk);
            #2 ps2_clk = 1'b0;
            repeat (3) @(posedge clk);
            #2 ps2_clk = 1'b1;
            repeat (HALF - 13) @(posedge clk);
            #2 ps2_clk = 1'b0;
            repeat (10) @(posedge clk);
            #2 ps2_clk = 1'b1;
            repeat (4) @(posedge clk);
            #2 ps2_clk = 1'b0;
            repeat (HALF - 14) @(posedge clk);
            #2 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        model_frame(8'h3C, 1'b1);
        do_read(1'b0, 1'b0, v);
        model_data(1'b0, e);
        checks++;
        if (v !== 32'h0000003C || v !== e) begin errors++; $display("FAIL glitch_data got %h exp 0000003c", v); end
        // Leave state behind, then reset in the middle of a frame
        send_frame(8'h77, 1'b1);
        send_frame(8'h12, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_data = 1'b1;
        do_reset();
        checks++;
        if (kbd_avail !== 1'b0) begin errors++; $display("FAIL midrst_avail got %b exp 0", kbd_avail); end
        do_read(1'b1, 1'b0, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL midrst_status got %h exp 0", v); end
        send_frame(8'h29, 1'b0);
        do_read(1'b0, 1'b0, v);
        model_data(1'b0, e);
        checks++;
        if (v !== 32'h00000029 || v !== e) begin errors++; $display("FAIL midrst_next got %h exp 00000029", v); end
    endtask

    task automatic test_random_traffic();
        logic [31:0] v, e;
        logic sel, stall;
        for (int n = 0; n < 12; n++) begin
            send_frame(8'($urandom), ($urandom % 4) == 0);
            for (int r = 0; r < int'($urandom % 3); r++) begin
                sel   = 1'($urandom);
                stall = ($urandom % 3) == 0;
                do_read(sel, stall, v);
                if (sel) model_status(stall, e);
                else     model_data(stall, e);
                checks++;
                if (v !== e) begin errors++; $display("FAIL rand_read sel=%b stall=%b got %h exp %h", sel, stall, v, e); end
            end
        end
        do_read(1'b1, 1'b0, v);
        model_status(1'b0, e);
        checks++;
        if (v !== e) begin errors++; $display("FAIL rand_status got %h exp %h", v, e); end
        for (int i = 0; i < 17 && q.size() != 0; i++) begin
            do_read(1'b0, 1'b0, v);
            model_data(1'b0, e);
            checks++;
            if (v !== e) begin errors++; $display("FAIL rand_drain got %h exp %h", v, e); end
        end
        checks++;
        if (kbd_avail !== 1'b0) begin errors++; $display("FAIL rand_empty got %b exp 0", kbd_avail); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity_error();
        test_overflow();
        test_stall();
        test_timeout();
        test_glitch_reset();
        test_random_traffic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
